// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// requester ids and the width of the read-latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and load/store share one
// memory port. Requests are sampled in IDLE, issued for one cycle, and
// reads wait LAT cycles before the data is returned to the winner.
// Ports:
//   clk, reset                    clock, async active-high reset
//   if_req/if_addr                fetch request in
//   if_gnt/if_valid/if_data       fetch grant, return pulse, data
//   ls_req/ls_we/ls_addr/ls_wdata load/store request in
//   ls_gnt/ls_valid/ls_rdata      load/store grant, return pulse, data
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata  shared memory port
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int n   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [n-1:0] if_addr,
    output logic         if_gnt,
    output logic         if_valid,
    output logic [n-1:0] if_data,
    input  logic         ls_req,
    input  logic         ls_we,
    input  logic [n-1:0] ls_addr,
    input  logic [n-1:0] ls_wdata,
    output logic         ls_gnt,
    output logic         ls_valid,
    output logic [n-1:0] ls_rdata,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    output logic         mem_we,
    output logic         mem_re,
    input  logic [n-1:0] mem_rdata
);

    arb_state_t       state_q, state_d;
    logic             win_q, win_d;
    logic             we_q, we_d;
    logic             last_q, last_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [n-1:0]     mem_addr_q, mem_addr_d;
    logic [n-1:0]     mem_wdata_q, mem_wdata_d;
    logic [n-1:0]     if_data_q, if_data_d;
    logic [n-1:0]     ls_rdata_q, ls_rdata_d;
    logic             if_gnt_q, if_gnt_d;
    logic             ls_gnt_q, ls_gnt_d;
    logic             if_valid_q, if_valid_d;
    logic             ls_valid_q, ls_valid_d;
    logic             mem_re_q, mem_re_d;
    logic             mem_we_q, mem_we_d;
    logic             sel;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        ls_rdata_d  = ls_rdata_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        sel         = REQ_IF;
        unique case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    // On conflict the side not granted last time wins.
                    if (if_req && ls_req) sel = ~last_q;
                    else                  sel = ls_req ? REQ_LS : REQ_IF;
                    state_d = ISSUE;
                    win_d   = sel;
                    last_d  = sel;
                    if (sel == REQ_LS) begin
                        ls_gnt_d    = 1'b1;
                        we_d        = ls_we;
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                        mem_we_d    = ls_we;
                        mem_re_d    = ~ls_we;
                    end else begin
                        if_gnt_d    = 1'b1;
                        we_d        = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_re_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d    = IDLE;
                    ls_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_W'(LAT);
                end
            end
            WAIT: begin
                // The count stops at zero; the last edge captures data.
                if (cnt_q <= LAT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (win_q == REQ_LS) begin
                        ls_rdata_d = mem_rdata;
                        ls_valid_d = 1'b1;
                    end else begin
                        if_data_d  = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= REQ_IF;
            we_q        <= 1'b0;
            last_q      <= REQ_IF;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            ls_rdata_q  <= '0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_valid_q  <= if_valid_d;
            ls_valid_q  <= ls_valid_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_valid  = if_valid_q;
    assign ls_valid  = ls_valid_q;
    assign if_data   = if_data_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: randomized fetch and load/store traffic
// against a cycle-level reference of the arbitration and latency rules.
module tb_mem_arb;

    localparam int N   = 8;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         if_req = 1'b0;
    logic [N-1:0] if_addr = '0;
    logic         if_gnt, if_valid;
    logic [N-1:0] if_data;
    logic         ls_req = 1'b0;
    logic         ls_we = 1'b0;
    logic [N-1:0] ls_addr = '0;
    logic [N-1:0] ls_wdata = '0;
    logic         ls_gnt, ls_valid;
    logic [N-1:0] ls_rdata;
    logic [N-1:0] mem_addr, mem_wdata;
    logic         mem_we, mem_re;
    logic [N-1:0] mem_rdata;

    mem_arb #(.n(N), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_valid(ls_valid),
        .ls_rdata(ls_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] rom(input logic [7:0] a);
        return (a * 8'd37) ^ 8'h5A;
    endfunction

    // Memory environment: read data appears exactly LAT cycles after mem_re.
    logic [7:0] wmem [256];
    logic       wr   [256] = '{default: 1'b0};
    logic       d_v  [LAT] = '{default: 1'b0};
    logic [7:0] d_a  [LAT];
    logic [7:0] junk = 8'h00;

    always @(posedge clk) begin
        if (mem_we) begin
            wmem[mem_addr] <= mem_wdata;
            wr[mem_addr]   <= 1'b1;
        end
        d_v[0] <= mem_re;
        d_a[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            d_v[i] <= d_v[i-1];
            d_a[i] <= d_a[i-1];
        end
        junk <= 8'($urandom);
    end

    always_comb begin
        mem_rdata = junk;
        if (d_v[LAT-1])
            mem_rdata = wr[d_a[LAT-1]] ? wmem[d_a[LAT-1]] : rom(d_a[LAT-1]);
    end

    // Reference contents seen by the program, updated in grant order.
    logic [7:0] ref_mem [256];

    typedef struct { logic st; logic [7:0] d; } ls_exp_t;
    logic [7:0] if_q [$];
    ls_exp_t    ls_q [$];
    logic       glog [$];

    // Request levels and cycle index seen at each rising edge.
    int         cyc = 0;
    logic       s_if = 0, s_ls = 0, s_we = 0;
    logic [7:0] s_ia = 0, s_la = 0, s_wd = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        s_if = if_req;  s_ia = if_addr;
        s_ls = ls_req;  s_la = ls_addr;
        s_we = ls_we;   s_wd = ls_wdata;
    end

    // Monitor: a grant must occur on the first free edge with a request,
    // a read returns LAT+1 cycles after its grant, a store 1 cycle after.
    initial begin
        int         v_if, v_ls, nf;
        logic       last, eif, els;
        logic [7:0] h_if, h_ls;
        ls_exp_t    e;
        v_if = -1; v_ls = -1; nf = 0; last = 1'b0;
        h_if = '0; h_ls = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_outs", 64'({if_gnt, if_valid, if_data, ls_gnt,
                      ls_valid, ls_rdata, mem_addr, mem_wdata, mem_we,
                      mem_re}), 64'(0));
                v_if = -1; v_ls = -1; nf = 0; last = 1'b0;
                h_if = '0; h_ls = '0;
                if_q.delete(); ls_q.delete();
            end else begin
                eif = (cyc >= nf) && s_if && (!s_ls || last);
                els = (cyc >= nf) && s_ls && (!s_if || !last);
                check("if_gnt", 64'(if_gnt), 64'(eif));
                check("ls_gnt", 64'(ls_gnt), 64'(els));
                check("mem_re", 64'(mem_re), 64'(eif || (els && !s_we)));
                check("mem_we", 64'(mem_we), 64'(els && s_we));
                if (eif) begin
                    check("if_mem_addr", 64'(mem_addr), 64'(s_ia));
                    last = 1'b0;
                    v_if = cyc + 1 + LAT;
                    nf   = v_if + 1;
                end
                if (els) begin
                    check("ls_mem_addr", 64'(mem_addr), 64'(s_la));
                    if (s_we) check("ls_mem_wdata", 64'(mem_wdata), 64'(s_wd));
                    last = 1'b1;
                    v_ls = cyc + 1 + (s_we ? 0 : LAT);
                    nf   = v_ls + 1;
                end
                check("if_valid", 64'(if_valid), 64'(cyc == v_if));
                if (cyc == v_if) begin
                    check("if_q_empty", 64'(if_q.size() == 0), 64'(0));
                    if (if_q.size() != 0) h_if = if_q.pop_front();
                    v_if = -1;
                end
                check("if_data", 64'(if_data), 64'(h_if));
                check("ls_valid", 64'(ls_valid), 64'(cyc == v_ls));
                if (cyc == v_ls) begin
                    check("ls_q_empty", 64'(ls_q.size() == 0), 64'(0));
                    if (ls_q.size() != 0) begin
                        e = ls_q.pop_front();
                        if (!e.st) h_ls = e.d;
                    end
                    v_ls = -1;
                end
                check("ls_rdata", 64'(ls_rdata), 64'(h_ls));
            end
        end
    end

    logic g_if = 0, g_ls = 0, vi = 0, vl = 0;
    logic if_hold = 0, ls_hold = 0;

    // Advance one cycle; a seen grant commits the request to the scoreboard.
    task automatic step();
        @(posedge clk);
        #1;
        g_if = if_gnt; g_ls = ls_gnt;
        vi = if_valid; vl = ls_valid;
        if (if_gnt) begin
            if_q.push_back(ref_mem[if_addr]);
            glog.push_back(1'b0);
            if (!if_hold) if_req = 1'b0;
        end
        if (ls_gnt) begin
            if (ls_we) begin
                ref_mem[ls_addr] = ls_wdata;
                ls_q.push_back('{1'b1, 8'h00});
            end else begin
                ls_q.push_back('{1'b0, ref_mem[ls_addr]});
            end
            glog.push_back(1'b1);
            if (!ls_hold) ls_req = 1'b0;
        end
    endtask

    task automatic wait_gnt(input logic ls, output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!(ls ? g_ls : g_if) && k < 20);
        check("gnt_timeout", 64'(ls ? g_ls : g_if), 64'(1));
    endtask

    initial begin
        int k, ng;
        for (int a = 0; a < 256; a++) ref_mem[a] = rom(8'(a));
        repeat (3) step();
        reset = 1'b0;
        check("post_rst_outs", 64'({if_gnt, if_valid, ls_gnt, ls_valid,
              mem_we, mem_re, mem_addr}), 64'(0));

        // Both requesters held high: grants alternate starting with LS.
        glog.delete();
        if_hold = 1'b1; ls_hold = 1'b1;
        if_addr = 8'h03; ls_addr = 8'h85; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        k = 0;
        while (glog.size() < 4 && k < 60) begin
            step();
            k++;
        end
        if_hold = 1'b0; ls_hold = 1'b0;
        if_req = 1'b0; ls_req = 1'b0;
        check("conflict_cnt", 64'(glog.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++)
            if (i < glog.size())
                check("conflict_order", 64'(glog[i]), 64'(i % 2 == 0));
        repeat (8) step();

        // Single fetch: grant next cycle, data LAT+1 cycles after grant.
        if_addr = 8'h05; if_req = 1'b1;
        wait_gnt(1'b0, k);
        check("if_gnt_lat", 64'(k), 64'(1));
        check("if_issue_re", 64'({mem_re, mem_we, mem_addr}),
              64'({1'b1, 1'b0, 8'h05}));
        k = 0;
        do begin step(); k++; end while (!vi && k < 20);
        check("if_valid_lat", 64'(k), 64'(LAT + 1));
        check("if_data_val", 64'(if_data), 64'(rom(8'h05)));
        repeat (2) step();

        // Store: acknowledged one cycle after issue, never a read strobe.
        ls_we = 1'b1; ls_addr = 8'h10; ls_wdata = 8'h7E; ls_req = 1'b1;
        wait_gnt(1'b1, k);
        check("st_issue", 64'({mem_we, mem_re, mem_addr, mem_wdata}),
              64'({1'b1, 1'b0, 8'h10, 8'h7E}));
        step();
        check("st_ack", 64'({ls_valid, mem_re, mem_we}),
              64'({1'b1, 1'b0, 1'b0}));
        repeat (2) step();

        // Load, then a fetch raised mid-transaction waits for IDLE.
        ls_we = 1'b0; ls_addr = 8'h10; ls_req = 1'b1;
        wait_gnt(1'b1, k);
        step();
        if_addr = 8'h22; if_req = 1'b1;
        wait_gnt(1'b0, k);
        check("if_after_load", 64'(k), 64'(4));
        repeat (8) step();

        // Request withdrawn before its sampling edge is dropped.
        if_addr = 8'h33; if_req = 1'b1;
        #2 if_req = 1'b0;
        ng = 0;
        repeat (4) begin
            step();
            ng += int'(g_if) + int'(g_ls) + int'(mem_re) + int'(mem_we);
        end
        check("withdraw", 64'(ng), 64'(0));

        // Reset during WAIT aborts the read.
        if_addr = 8'h44; if_req = 1'b1;
        wait_gnt(1'b0, k);
        step();
        reset = 1'b1;
        #1;
        check("rst_async", 64'({if_gnt, if_valid, if_data, ls_gnt, ls_valid,
              ls_rdata, mem_addr, mem_wdata, mem_we, mem_re}), 64'(0));
        repeat (3) step();
        reset = 1'b0;
        step();
        if_addr = 8'h45; if_req = 1'b1;
        wait_gnt(1'b0, k);
        check("gnt_after_rst", 64'(k), 64'(1));
        repeat (8) step();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            step();
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_addr = 8'($urandom_range(0, 127));
                    if_req  = 1'b1;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                if_req = 1'b0;
            end
            if (!ls_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    ls_we    = 1'($urandom_range(0, 1));
                    ls_addr  = 8'(8'h80 + $urandom_range(0, 15));
                    ls_wdata = 8'($urandom);
                    ls_req   = 1'b1;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                ls_req = 1'b0;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (20) step();
        check("drain_if_q", 64'(if_q.size()), 64'(0));
        check("drain_ls_q", 64'(ls_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
